// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared states, display constants and leading-blank helper for the seven-segment scheduler
package seg_pkg;

    typedef enum logic [1:0] {
        ST_SCORE   = 2'd0,
        ST_HIGH    = 2'd1,
        ST_MSG_ON  = 2'd2,
        ST_MSG_OFF = 2'd3
    } seg_state_t;

    localparam logic [3:0]  NIB_DASH   = 4'hA;
    localparam logic [3:0]  NIB_BLANK  = 4'hB;
    localparam logic [3:0]  NIB_LOW    = 4'hC;
    localparam logic [15:0] WORD_BLANK = {4{NIB_BLANK}};
    localparam logic [15:0] WORD_DASH  = {4{NIB_DASH}};

    // Blank zero nibbles from the top down; the units nibble always stays visible.
    function automatic logic [15:0] lead_blank(input logic [15:0] w);
        logic [15:0] r;
        logic        lead;
        r    = w;
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && (w[i*4 +: 4] == 4'h0)) begin
                r[i*4 +: 4] = NIB_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// rtl/seg_tick_gen.sv - slow-tick prescaler, restartable from the scheduler on every view change
module seg_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic clr,
    input  logic sync_clr,
    output logic tick
);

    localparam int            CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (sync_clr || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/seg_display_scheduler.sv
// rtl/seg_display_scheduler.sv - score/high rotation and blinking messages for the 4-digit display; SEG_LEAD_BLANK_EN blanks leading zeros
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int TICK_DIV  = 25_000_000,
    parameter int ROT_TICKS = 8,
    parameter int BLINKS    = 3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] score_bcd,
    input  logic [15:0] high_bcd,
    input  logic        rot_en,
    input  logic        msg_req,
    input  logic [15:0] msg_code,
    output logic        msg_ack,
    output logic        msg_done,
    output logic        busy,
    output logic [15:0] x
);

    localparam int            PW      = $clog2(ROT_TICKS + 1);
    localparam int            BW      = $clog2(BLINKS + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(ROT_TICKS - 1);
    localparam logic [PW-1:0] PH_MAX  = PW'(ROT_TICKS);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINKS);

    seg_state_t    r_state;
    seg_state_t    w_next;
    logic [PW-1:0] r_phase;
    logic [BW-1:0] r_blink;
    logic [15:0]   r_code;
    logic [15:0]   r_x;
    logic          r_ack;
    logic          r_done;

    logic          w_tick;
    logic          w_sync_clr;
    logic          w_ack;
    logic          w_done;
    logic          w_rot_due;
    logic [BW-1:0] w_blink_inc;
    logic [15:0]   w_live;
    logic [15:0]   w_view;

    seg_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .clr      (clr),
        .sync_clr (w_sync_clr),
        .tick     (w_tick)
    );

    // Phase saturates, so a rotation held off by rot_en fires on the next tick once enabled.
    assign w_rot_due   = w_tick && (r_phase >= PH_LAST);
    assign w_blink_inc = r_blink + BW'(1);
    assign w_sync_clr  = (w_next != r_state);

    always_comb begin
        w_next = r_state;
        w_ack  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_SCORE: begin
                if (msg_req) begin
                    w_ack  = 1'b1;
                    w_next = ST_MSG_ON;
                end else if (rot_en && w_rot_due) begin
                    w_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (msg_req) begin
                    w_ack  = 1'b1;
                    w_next = ST_MSG_ON;
                end else if (!rot_en || w_rot_due) begin
                    w_next = ST_SCORE;
                end
            end
            ST_MSG_ON: begin
                if (w_tick) begin
                    if (w_blink_inc == BL_LAST) begin
                        w_done = 1'b1;
                        w_next = ST_SCORE;
                    end else begin
                        w_next = ST_MSG_OFF;
                    end
                end
            end
            ST_MSG_OFF: begin
                if (w_tick) begin
                    w_next = ST_MSG_ON;
                end
            end
            default: w_next = ST_SCORE;
        endcase
    end

    always_comb begin
        w_live = (r_state == ST_HIGH) ? high_bcd : score_bcd;
`ifdef SEG_LEAD_BLANK_EN
        w_live = lead_blank(w_live);
`endif
        case (r_state)
            ST_MSG_ON:  w_view = r_code;
            ST_MSG_OFF: w_view = WORD_BLANK;
            default:    w_view = w_live;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_SCORE;
            r_phase <= '0;
            r_blink <= '0;
            r_code  <= '0;
            r_x     <= WORD_DASH;
            r_ack   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_x     <= w_view;
            r_ack   <= w_ack;
            r_done  <= w_done;
            if (w_ack) begin
                r_code  <= msg_code;
                r_blink <= '0;
            end else if ((r_state == ST_MSG_ON) && w_tick) begin
                r_blink <= w_blink_inc;
            end
            if (w_sync_clr) begin
                r_phase <= '0;
            end else if (w_tick && (r_phase != PH_MAX)) begin
                r_phase <= r_phase + PW'(1);
            end
        end
    end

    assign msg_ack  = r_ack;
    assign msg_done = r_done;
    assign busy     = (r_state == ST_MSG_ON) || (r_state == ST_MSG_OFF);
    assign x        = r_x;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb/tb_seg_display_scheduler.sv - directed and randomized checks of seg_display_scheduler against a cycle-count model
module tb_seg_display_scheduler;

    localparam int TD = 4;
    localparam int RT = 3;
    localparam int BL = 2;

    logic        clk       = 1'b0;
    logic        clr       = 1'b1;
    logic [15:0] score_bcd = 16'h0123;
    logic [15:0] high_bcd  = 16'h0950;
    logic        rot_en    = 1'b0;
    logic        msg_req   = 1'b0;
    logic [15:0] msg_code  = 16'h0000;
    logic        msg_ack;
    logic        msg_done;
    logic        busy;
    logic [15:0] x;

    int   n_cmp  = 0;
    int   n_bad  = 0;
    logic chk_en = 1'b0;

    seg_display_scheduler #(
        .TICK_DIV  (TD),
        .ROT_TICKS (RT),
        .BLINKS    (BL)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .score_bcd (score_bcd),
        .high_bcd  (high_bcd),
        .rot_en    (rot_en),
        .msg_req   (msg_req),
        .msg_code  (msg_code),
        .msg_ack   (msg_ack),
        .msg_done  (msg_done),
        .busy      (busy),
        .x         (x)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fmt(input logic [15:0] w);
`ifdef SEG_LEAD_BLANK_EN
        int top;
        top = 0;
        for (int i = 1; i < 4; i++) if (w[i*4 +: 4] != 4'h0) top = i;
        for (int i = top + 1; i < 4; i++) w[i*4 +: 4] = 4'hB;
`endif
        return w;
    endfunction

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Model: view mode (0 score, 1 high, 2 message) plus cycles spent in it.
    int          m_st   = 0;
    int          m_k    = 0;
    logic [15:0] m_code = 16'h0000;
    logic [15:0] e_x    = 16'hAAAA;
    logic        e_ack  = 1'b0;
    logic        e_done = 1'b0;
    logic        e_busy = 1'b0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_st   <= 0;
            m_k    <= 0;
            m_code <= 16'h0000;
            e_x    <= 16'hAAAA;
            e_ack  <= 1'b0;
            e_done <= 1'b0;
            e_busy <= 1'b0;
        end else begin : mdl
            int          nst;
            int          ticks;
            logic        tk;
            logic        ack;
            logic        done;
            logic [15:0] code;
            logic [15:0] vx;
            nst   = m_st;
            code  = m_code;
            ack   = 1'b0;
            done  = 1'b0;
            tk    = (m_k % TD) == TD - 1;
            ticks = (m_k + 1) / TD;
            if (m_st == 0)      vx = fmt(score_bcd);
            else if (m_st == 1) vx = fmt(high_bcd);
            else                vx = ((m_k / TD) % 2 == 0) ? m_code : 16'hBBBB;
            if (m_st != 2 && msg_req) begin
                ack  = 1'b1;
                code = msg_code;
                nst  = 2;
            end else if (m_st == 0 && rot_en && tk && ticks >= RT) begin
                nst = 1;
            end else if (m_st == 1 && (!rot_en || (tk && ticks >= RT))) begin
                nst = 0;
            end else if (m_st == 2 && m_k == (2 * BL - 1) * TD - 1) begin
                done = 1'b1;
                nst  = 0;
            end
            m_st   <= nst;
            m_k    <= (nst != m_st) ? 0 : m_k + 1;
            m_code <= code;
            e_x    <= vx;
            e_ack  <= ack;
            e_done <= done;
            e_busy <= (nst == 2);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("x",        32'(x),        32'(e_x));
            check("msg_ack",  32'(msg_ack),  32'(e_ack));
            check("msg_done", 32'(msg_done), 32'(e_done));
            check("busy",     32'(busy),     32'(e_busy));
        end
    end

    initial begin
        logic [15:0] sc_exp;
        logic [15:0] hi_exp;
        int          acks;
        int          waited;
`ifdef SEG_LEAD_BLANK_EN
        sc_exp = 16'hB123;
        hi_exp = 16'hB950;
`else
        sc_exp = 16'h0123;
        hi_exp = 16'h0950;
`endif
        rot_en = 1'b1;
        repeat (3) step();
        chk_en = 1'b1;
        check("reset_x",    32'(x),        32'h0000AAAA);
        check("reset_ack",  32'(msg_ack),  32'd0);
        check("reset_done", 32'(msg_done), 32'd0);
        check("reset_busy", 32'(busy),     32'd0);
        clr = 1'b0;

        step();
        check("first_x", 32'(x), 32'(sc_exp));
        repeat (11) step();
        check("rot_pre", 32'(x), 32'(sc_exp));
        step();
        check("rot_high", 32'(x), 32'(hi_exp));
        repeat (11) step();
        check("high_hold", 32'(x), 32'(hi_exp));
        step();
        check("rot_back", 32'(x), 32'(sc_exp));

        repeat (12) step();
        check("high_again", 32'(x), 32'(hi_exp));
        step();
        rot_en = 1'b0;
        step();
        check("drop_hold", 32'(x), 32'(hi_exp));
        step();
        check("drop_ret", 32'(x), 32'(sc_exp));

        msg_code = 16'hAAAA;
        msg_req  = 1'b1;
        step();
        check("msg_ack", 32'(msg_ack), 32'd1);
        check("msg_busy", 32'(busy), 32'd1);
        msg_req = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("msg_seq", 32'(x), (i <= 4 || i >= 9) ? 32'h0000AAAA : 32'h0000BBBB);
        end
        check("msg_done", 32'(msg_done), 32'd1);
        check("msg_busy_end", 32'(busy), 32'd0);
        step();
        check("msg_ret", 32'(x), 32'(sc_exp));

        rot_en = 1'b1;
        repeat (10) step();
        msg_code = 16'h1234;
        msg_req  = 1'b1;
        step();
        check("coll_ack", 32'(msg_ack), 32'd1);
        step();
        check("coll_x", 32'(x), 32'h00001234);

        acks   = 0;
        waited = 0;
        while (msg_done !== 1'b1 && waited < 100) begin
            step();
            waited++;
            if (msg_ack) acks++;
        end
        check("held_done_seen", 32'(waited < 100), 32'd1);
        check("held_extra_acks", 32'(acks), 32'd0);
        step();
        check("held_reack", 32'(msg_ack), 32'd1);
        msg_req = 1'b0;

        repeat (5) step();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_blank", 32'(x), 32'h0000BBBB);
        clr = 1'b1;
        #1;
        check("mid_rst_x", 32'(x), 32'h0000AAAA);
        check("mid_rst_busy", 32'(busy), 32'd0);
        step();
        check("mid_rst_done", 32'(msg_done), 32'd0);
        step();
        clr = 1'b0;
        step();
        check("mid_rst_after_done", 32'(msg_done), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(0, 7) == 0) score_bcd = rnd_bcd();
            if ($urandom_range(0, 7) == 0) high_bcd = rnd_bcd();
            if ($urandom_range(0, 15) == 0) rot_en = ~rot_en;
            if (msg_req && msg_ack) begin
                msg_req = 1'b0;
            end else if (!msg_req && $urandom_range(0, 40) == 0) begin
                msg_req  = 1'b1;
                msg_code = 16'($urandom);
            end
            clr = ($urandom_range(0, 999) == 0);
        end
        clr = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
